// File: rtl/sr_excitation_driver.sv
// Drives a WIDTH-bit target word, LSB first, into an external SR flip-flop as
// set/reset commands. It reads back q, checks it against an internal model and counts mismatches.
module sr_excitation_driver #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         s,
    output logic                         r,
    input  logic                         q_fb,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(WIDTH+1)-1:0]   mis_cnt
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST    = IW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_shift;
    logic [IW-1:0]    idx;
    logic             exp_q;

    assign sh_shift = sh >> 1;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = DRIVE;
            end
            DRIVE: begin
                busy     = 1'b1;
                state_nx = SETTLE;
            end
            SETTLE: begin
                busy     = 1'b1;
                state_nx = (idx == LAST) ? DONE : DRIVE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // s/r are registered, so the command for a bit is computed on the edge
    // that enters DRIVE. The command compares the next target bit with the model's current q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s       <= 1'b0;
            r       <= 1'b0;
            exp_q   <= 1'b0;
            err     <= 1'b0;
            mis_cnt <= '0;
            idx     <= '0;
            sh      <= '0;
        end else begin
            s <= 1'b0;
            r <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh      <= in_data;
                        exp_q   <= q_fb;
                        err     <= 1'b0;
                        mis_cnt <= '0;
                        idx     <= '0;
                        s       <= in_data[0] & ~q_fb;
                        r       <= ~in_data[0] & q_fb;
                    end
                end
                DRIVE: exp_q <= sh[0];
                SETTLE: begin
                    if (q_fb != exp_q) begin
                        err <= 1'b1;
                        if (mis_cnt != CNT_MAX) mis_cnt <= mis_cnt + CW'(1);
                    end
                    if (idx != LAST) begin
                        idx <= idx + IW'(1);
                        sh  <= sh_shift;
                        s   <= sh_shift[0] & ~exp_q;
                        r   <= ~sh_shift[0] & exp_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_excitation_driver.sv
// Directed bench for sr_excitation_driver. It uses an ideal SR flip-flop model
// that can be forced stuck at 0 for the readback fault case.
module tb_sr_excitation_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       s, r, q_fb, busy, done, err;
    logic [3:0] mis_cnt;

    logic ff_q = 1'b0;
    logic ff_clr = 1'b0;
    logic stuck = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [1:0] cmd [8];
    int         done_cyc, quiet_bad;
    logic       err_c1, err_c3, err_done, err_c18, busy_c1, rdy_c17, rdy_c18;
    logic [3:0] cnt_c1, cnt_c3, cnt_done;

    sr_excitation_driver #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .s(s), .r(r), .q_fb(q_fb), .busy(busy),
        .done(done), .err(err), .mis_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ff_clr)          ff_q <= 1'b0;
        else if (s && !r)    ff_q <= 1'b1;
        else if (r && !s)    ff_q <= 1'b0;
    end
    assign q_fb = stuck ? 1'b0 : ff_q;

    always @(negedge clk) begin
        checks++;
        assert (!(s && r)) else begin
            errors++;
            $display("FAIL s_r_exclusive s=%b r=%b want not both 1", s, r);
        end
    end

    task automatic clear_ff();
        ff_clr = 1'b1;
        @(posedge clk); #1;
        ff_clr = 1'b0;
    endtask

    // Stimulus helper: accepts one frame and records what happens in cycles 1..18 after the accept edge.
    task automatic run_frame(input logic [7:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL accept_wait in_ready=%b want 1", in_ready); end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
        done_cyc  = 0;
        quiet_bad = 0;
        for (int c = 1; c <= 18; c++) begin
            if (c <= 16 && (c % 2) == 1) cmd[(c - 1) / 2] = {s, r};
            else if (s || r) quiet_bad++;
            if (done && done_cyc == 0) done_cyc = c;
            if (c == 1)  begin err_c1 = err; cnt_c1 = mis_cnt; busy_c1 = busy; end
            if (c == 3)  begin err_c3 = err; cnt_c3 = mis_cnt; end
            if (c == 17) begin err_done = err; cnt_done = mis_cnt; rdy_c17 = in_ready; end
            if (c == 18) begin err_c18 = err; rdy_c18 = in_ready; end
            if (c < 18) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        checks += 6;
        if (s !== 1'b0)        begin errors++; $display("FAIL reset_s got %b want 0", s); end
        if (r !== 1'b0)        begin errors++; $display("FAIL reset_r got %b want 0", r); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if ({err, mis_cnt} !== 5'd0) begin errors++; $display("FAIL reset_err_cnt got %b/%0d want 0/0", err, mis_cnt); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_pattern_a6();
        logic [1:0] want [8];
        want = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10};
        clear_ff();
        run_frame(8'hA6);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cmd[k] !== want[k]) begin errors++; $display("FAIL a6_cmd bit%0d sr=%b want %b", k, cmd[k], want[k]); end
        end
        checks += 8;
        if (busy_c1 !== 1'b1)  begin errors++; $display("FAIL a6_busy got %b want 1", busy_c1); end
        if (quiet_bad != 0)    begin errors++; $display("FAIL a6_settle_quiet got %0d want 0", quiet_bad); end
        if (done_cyc != 17)    begin errors++; $display("FAIL a6_done_cycle got %0d want 17", done_cyc); end
        if (rdy_c17 !== 1'b0)  begin errors++; $display("FAIL a6_ready_in_done got %b want 0", rdy_c17); end
        if (rdy_c18 !== 1'b1)  begin errors++; $display("FAIL a6_ready_after got %b want 1", rdy_c18); end
        if (err_done !== 1'b0) begin errors++; $display("FAIL a6_err got %b want 0", err_done); end
        if (cnt_done !== 4'd0) begin errors++; $display("FAIL a6_mis_cnt got %0d want 0", cnt_done); end
        if (ff_q !== 1'b1)     begin errors++; $display("FAIL a6_final_q got %b want 1", ff_q); end
    endtask

    task automatic test_all_ones();
        int sp, rp;
        clear_ff();
        run_frame(8'hFF);
        sp = 0; rp = 0;
        for (int k = 0; k < 8; k++) begin sp += int'(cmd[k][1]); rp += int'(cmd[k][0]); end
        checks += 5;
        if (cmd[0] !== 2'b10)  begin errors++; $display("FAIL ff_bit0 sr=%b want 10", cmd[0]); end
        if (sp != 1)           begin errors++; $display("FAIL ff_set_pulses got %0d want 1", sp); end
        if (rp != 0)           begin errors++; $display("FAIL ff_reset_pulses got %0d want 0", rp); end
        if (quiet_bad != 0)    begin errors++; $display("FAIL ff_settle_quiet got %0d want 0", quiet_bad); end
        if (err_done !== 1'b0) begin errors++; $display("FAIL ff_err got %b want 0", err_done); end
    endtask

    task automatic test_stuck_fault();
        clear_ff();
        stuck = 1'b1;
        run_frame(8'h01);
        checks += 6;
        if (err_c1 !== 1'b0)   begin errors++; $display("FAIL stuck_err_c1 got %b want 0", err_c1); end
        if (err_c3 !== 1'b1)   begin errors++; $display("FAIL stuck_err_bit0 got %b want 1", err_c3); end
        if (cnt_c3 !== 4'd1)   begin errors++; $display("FAIL stuck_cnt_bit0 got %0d want 1", cnt_c3); end
        if (err_done !== 1'b1) begin errors++; $display("FAIL stuck_err_done got %b want 1", err_done); end
        if (cnt_done !== 4'd1) begin errors++; $display("FAIL stuck_cnt_done got %0d want 1", cnt_done); end
        if (err_c18 !== 1'b1)  begin errors++; $display("FAIL stuck_err_hold got %b want 1", err_c18); end
        run_frame(8'h00);
        checks += 3;
        if ({err_c1, cnt_c1} !== 5'd0) begin errors++; $display("FAIL next_clear got %b/%0d want 0/0", err_c1, cnt_c1); end
        if (err_done !== 1'b0) begin errors++; $display("FAIL next_err_done got %b want 0", err_done); end
        if (done_cyc != 17)    begin errors++; $display("FAIL next_done_cycle got %0d want 17", done_cyc); end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int dn;
        clear_ff();
        in_valid = 1'b1;
        in_data  = 8'h10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks += 4;
        if ({s, r} !== 2'b00)  begin errors++; $display("FAIL mid_sr got %b want 00", {s, r}); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        if (mis_cnt !== 4'd0)  begin errors++; $display("FAIL mid_mis_cnt got %0d want 0", mis_cnt); end
        dn = 0;
        repeat (25) begin if (done) dn++; @(posedge clk); #1; end
        checks++;
        if (dn != 0) begin errors++; $display("FAIL mid_no_done got %0d pulses want 0", dn); end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int rdy_hi, n;
        clear_ff();
        rdy_hi = 0;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        for (int c = 0; c < 56; c++) begin
            if (in_ready) begin rdy_hi++; acc.push_back(c); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks += 2;
        if (acc.size() != 4) begin errors++; $display("FAIL b2b_accepts got %0d want 4", acc.size()); end
        if (rdy_hi != 4)     begin errors++; $display("FAIL b2b_ready_cycles got %0d want 4", rdy_hi); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 18) begin
                errors++; $display("FAIL b2b_spacing %0d got %0d want 18", i, acc[i] - acc[i-1]);
            end
        end
        n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL b2b_drain in_ready=%b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_pattern_a6();
        test_all_ones();
        test_stuck_fault();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
